// File: rtl/shift_pipe_if.sv
// Request/response bundle for shift_pipe: valid/ready request with operands in,
// valid/ready result out.
interface shift_pipe_if #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] Rs1;
    logic [SHW-1:0]  Shamt;
    logic            funct3_2;
    logic            funct7_5;
    logic            Rot;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] Result;

    modport master (
        output in_valid, Rs1, Shamt, funct3_2, funct7_5, Rot, out_ready,
        input  in_ready, out_valid, Result
    );

    modport slave (
        input  in_valid, Rs1, Shamt, funct3_2, funct7_5, Rot, out_ready,
        output in_ready, out_valid, Result
    );
endinterface

// File: rtl/shift_pipe.sv
// Two-stage SLL/SRL/SRA shifter built on one shared right-shift network (XLEN 32 or 64).
// Define SHIFT_PIPE_ROTATE_EN to add ROL/ROR when Rot=1.
module shift_pipe #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input logic         CLK,
    input logic         RST,
    input logic         flush,
    shift_pipe_if.slave bus
);
    localparam int LO_LVLS = SHW / 2;
    localparam int HI_LVLS = SHW - LO_LVLS;

    // ---------------- control state ----------------
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic s1_advance;
    logic accept;

    // ---------------- input decode ----------------
`ifdef SHIFT_PIPE_ROTATE_EN
    logic in_rot;
    logic s1_rot_q;
    assign in_rot = bus.Rot;
`else
    localparam logic in_rot = 1'b0;
`endif

    logic in_left;
    logic in_fill;
    logic in_zero;

    // Left shifts and ROL are right operations on the bit-reversed operand.
    assign in_left = !bus.funct3_2;
    assign in_zero = !in_rot && bus.funct7_5 && !bus.funct3_2;
    assign in_fill = !in_rot && bus.funct7_5 && bus.funct3_2 && bus.Rs1[XLEN-1];

    logic [XLEN-1:0] rs1_rev;
    assign rs1_rev = {<<{bus.Rs1}};

    // ---------------- stage 1 network: low Shamt bits ----------------
    logic [LO_LVLS:0][XLEN-1:0] lvl1;
    assign lvl1[0] = in_left ? rs1_rev : bus.Rs1;

    for (genvar k = 0; k < LO_LVLS; k++) begin : g_lvl1
        localparam int S = 2 ** k;
        logic [XLEN-1:0] wrap;
`ifdef SHIFT_PIPE_ROTATE_EN
        assign wrap = in_rot ? (lvl1[k] << (XLEN - S))
                             : ({XLEN{in_fill}} << (XLEN - S));
`else
        assign wrap = {XLEN{in_fill}} << (XLEN - S);
`endif
        assign lvl1[k+1] = bus.Shamt[k] ? ((lvl1[k] >> S) | wrap) : lvl1[k];
    end

    // ---------------- stage 1 payload ----------------
    logic [XLEN-1:0]    s1_data_q;
    logic [HI_LVLS-1:0] s1_shamt_hi_q;
    logic               s1_left_q;
    logic               s1_fill_q;
    logic               s1_zero_q;

    // ---------------- stage 2 network: remaining Shamt bits ----------------
    logic [HI_LVLS:0][XLEN-1:0] lvl2;
    assign lvl2[0] = s1_data_q;

    for (genvar j = 0; j < HI_LVLS; j++) begin : g_lvl2
        localparam int S = 2 ** (LO_LVLS + j);
        logic [XLEN-1:0] wrap;
`ifdef SHIFT_PIPE_ROTATE_EN
        assign wrap = s1_rot_q ? (lvl2[j] << (XLEN - S))
                               : ({XLEN{s1_fill_q}} << (XLEN - S));
`else
        assign wrap = {XLEN{s1_fill_q}} << (XLEN - S);
`endif
        assign lvl2[j+1] = s1_shamt_hi_q[j] ? ((lvl2[j] >> S) | wrap) : lvl2[j];
    end

    logic [XLEN-1:0] s2_fwd;
    logic [XLEN-1:0] s2_rev;
    logic [XLEN-1:0] result_q, result_d;

    assign s2_fwd = lvl2[HI_LVLS];
    assign s2_rev = {<<{s2_fwd}};

    // ---------------- handshake ----------------
    assign s1_advance   = s1_valid_q && (!s2_valid_q || bus.out_ready);
    assign bus.in_ready = !RST && !flush && (!s1_valid_q || s1_advance);
    assign accept       = bus.in_valid && bus.in_ready;

    assign bus.out_valid = s2_valid_q;
    assign bus.Result    = result_q;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path infers a latch.
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        result_d   = s2_fwd;

        if (accept) begin
            s1_valid_d = 1'b1;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end

        if (s1_advance) begin
            s2_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            s2_valid_d = 1'b0;
        end

        if (s1_zero_q) begin
            result_d = '0;
        end else if (s1_left_q) begin
            result_d = s2_rev;
        end
    end

    // Reset outranks flush, and flush outranks any handshake.
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
        end else begin
            if (flush) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
            end else begin
                s1_valid_q <= s1_valid_d;
                s2_valid_q <= s2_valid_d;
            end
            if (s1_advance) begin
                result_q <= result_d;
            end
        end
    end

    // NOTE: payload registers carry no reset; the valid bits alone decide whether they mean anything.
    always_ff @(posedge CLK) begin
        if (accept) begin
            s1_data_q     <= lvl1[LO_LVLS];
            s1_shamt_hi_q <= bus.Shamt[SHW-1:LO_LVLS];
            s1_left_q     <= in_left;
            s1_fill_q     <= in_fill;
            s1_zero_q     <= in_zero;
`ifdef SHIFT_PIPE_ROTATE_EN
            s1_rot_q      <= in_rot;
`endif
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe: 32- and 64-bit instances share handshake stimulus,
// results are predicted by a plain-arithmetic model and checked by a monitor.
module tb_shift_pipe;

    logic CLK = 1'b0;
    logic RST;
    logic flush;

    logic        in_valid;
    logic        out_ready;
    logic [63:0] rs1;
    logic [5:0]  sh;
    logic        f3;
    logic        f7;
    logic        rot;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int pops = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    shift_pipe_if #(.XLEN(32)) b32 ();
    shift_pipe_if #(.XLEN(64)) b64 ();

    assign b32.in_valid  = in_valid;
    assign b32.Rs1       = rs1[31:0];
    assign b32.Shamt     = sh[4:0];
    assign b32.funct3_2  = f3;
    assign b32.funct7_5  = f7;
    assign b32.Rot       = rot;
    assign b32.out_ready = out_ready;

    assign b64.in_valid  = in_valid;
    assign b64.Rs1       = rs1;
    assign b64.Shamt     = sh;
    assign b64.funct3_2  = f3;
    assign b64.funct7_5  = f7;
    assign b64.Rot       = rot;
    assign b64.out_ready = out_ready;

    shift_pipe #(.XLEN(32)) u32 (.CLK(CLK), .RST(RST), .flush(flush), .bus(b32.slave));
    shift_pipe #(.XLEN(64)) u64 (.CLK(CLK), .RST(RST), .flush(flush), .bus(b64.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the instruction's meaning on a w-bit word, in plain arithmetic.
    function automatic logic [63:0] model(input int w, input logic [63:0] a_in, input int s,
                                          input logic fn3, input logic fn7, input logic r);
        logic [63:0] mask;
        logic [63:0] a;
        logic        rot_on;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        a    = a_in & mask;
`ifdef SHIFT_PIPE_ROTATE_EN
        rot_on = r;
`else
        rot_on = 1'b0;
`endif
        if (rot_on) begin
            if (!fn3) return ((a << s) | (a >> (w - s))) & mask;
            return ((a >> s) | (a << (w - s))) & mask;
        end
        case ({fn7, fn3})
            2'b00:   return (a << s) & mask;
            2'b01:   return a >> s;
            2'b11:   return (a >> s) | (a[w-1] ? (mask & ~(mask >> s)) : 64'd0);
            default: return 64'd0;
        endcase
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [63:0] q32[$];
    logic [63:0] q64[$];
    bit          stall32 = 0, stall64 = 0;
    logic [63:0] held32, held64;

    always @(negedge CLK) begin
        if (stall32) begin
            check("hold_valid32", b32.out_valid, 1'b1);
            check("hold_data32", b32.Result, held32);
        end
        if (stall64) begin
            check("hold_valid64", b64.out_valid, 1'b1);
            check("hold_data64", b64.Result, held64);
        end

        // A full pipe holds two items; it can only take more when the output drains.
        check("in_ready32", b32.in_ready, !RST && !flush && (q32.size() < 2 || out_ready));
        check("in_ready64", b64.in_ready, !RST && !flush && (q64.size() < 2 || out_ready));

        if (!RST && b32.out_valid && out_ready) begin
            if (q32.size() == 0) check("spurious32", b32.out_valid, 1'b0);
            else begin
                check("result32", b32.Result, q32.pop_front());
                pops++;
            end
        end
        if (!RST && b64.out_valid && out_ready) begin
            if (q64.size() == 0) check("spurious64", b64.out_valid, 1'b0);
            else check("result64", b64.Result, q64.pop_front());
        end

        if (in_valid && b32.in_ready) q32.push_back(model(32, rs1, int'(sh[4:0]), f3, f7, rot));
        if (in_valid && b64.in_ready) q64.push_back(model(64, rs1, int'(sh), f3, f7, rot));
        if (RST || flush) begin
            q32.delete();
            q64.delete();
        end

        stall32 = !RST && !flush && b32.out_valid && !out_ready;
        stall64 = !RST && !flush && b64.out_valid && !out_ready;
        held32  = {32'd0, b32.Result};
        held64  = b64.Result;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present one request until accepted; acc is the cycle it was seen accepted.
    task automatic send(input logic [63:0] a, input logic [5:0] s, input logic fn3,
                        input logic fn7, input logic r, output int acc);
        step();
        rs1 = a; sh = s; f3 = fn3; f7 = fn7; rot = r; in_valid = 1'b1;
        acc = -1;
        for (int t = 0; t < 20 && acc < 0; t++) begin
            @(negedge CLK);
            if (b32.in_ready) acc = cyc;
            step();
        end
        in_valid = 1'b0;
        check("accept_timeout", acc >= 0, 1'b1);
    endtask

    task automatic wait_out(input int acc, output int lat);
        lat = -1;
        for (int t = 0; t < 10 && lat < 0; t++) begin
            @(negedge CLK);
            if (b32.out_valid) lat = cyc - acc;
        end
    endtask

    task automatic op_lat(input string name, input logic [63:0] a, input logic [5:0] s,
                          input logic fn3, input logic fn7, input logic r);
        int acc, lat;
        send(a, s, fn3, fn7, r, acc);
        wait_out(acc, lat);
        check(name, lat, 2);
    endtask

    task automatic drain();
        step();
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int t = 0; t < 12 && (q32.size() != 0 || q64.size() != 0); t++) step();
        check("drain32", q32.size(), 0);
        check("drain64", q64.size(), 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int acc, lat, k, c, pops0;
        bit saw_stall;

        RST = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rs1 = '0; sh = '0; f3 = 1'b0; f7 = 1'b0; rot = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid32", b32.out_valid, 1'b0);
        check("rst_result32", b32.Result, 64'd0);
        check("rst_in_ready32", b32.in_ready, 1'b0);
        check("rst_out_valid64", b64.out_valid, 1'b0);
        check("rst_result64", b64.Result, 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("in_ready_after_rst32", b32.in_ready, 1'b1);
        check("in_ready_after_rst64", b64.in_ready, 1'b1);

        // SRA of the sign bit by 31, then the 64-bit corner shifts and the illegal code.
        op_lat("lat_sra31", 64'h0000_0000_8000_0000, 6'd31, 1'b1, 1'b1, 1'b0);
        op_lat("lat_sll63", 64'h1, 6'd63, 1'b0, 1'b0, 1'b0);
        op_lat("lat_srl63", 64'h8000_0000_0000_0000, 6'd63, 1'b1, 1'b0, 1'b0);
        op_lat("lat_illegal", 64'hDEAD_BEEF_CAFE_F00D, 6'd5, 1'b0, 1'b1, 1'b0);
        op_lat("lat_rot_ror4", 64'h1, 6'd4, 1'b1, 1'b0, 1'b1);
        op_lat("lat_rot_rol4", 64'h8000_0000_8000_0000, 6'd4, 1'b0, 1'b1, 1'b1);
        op_lat("lat_sll0", 64'hF00F_1234_8765_ABCD, 6'd0, 1'b0, 1'b0, 1'b0);
        op_lat("lat_srl0", 64'hF00F_1234_8765_ABCD, 6'd0, 1'b1, 1'b0, 1'b0);
        op_lat("lat_sra0", 64'hF00F_1234_8765_ABCD, 6'd0, 1'b1, 1'b1, 1'b0);

        // Eight back-to-back requests with the consumer stalled for cycles 3..6.
        drain();
        pops0 = pops; k = 0; c = 0; saw_stall = 0;
        while (k < 8 && c < 40) begin
            rs1 = {$urandom, $urandom}; sh = 6'($urandom); f3 = 1'($urandom); f7 = 1'($urandom);
            rot = 1'b0; in_valid = 1'b1;
            out_ready = !(c >= 3 && c <= 6);
            @(negedge CLK);
            if (!b32.in_ready) saw_stall = 1;
            acc = b32.in_ready ? 1 : 0;
            step();
            k += acc;
            c++;
        end
        in_valid = 1'b0;
        check("b2b_accepted", k, 8);
        check("b2b_saw_stall", saw_stall, 1'b1);
        drain();
        check("b2b_results", pops - pops0, 8);

        // Two in flight, then flush with a competing request.
        step();
        out_ready = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 6'd3, 1'b0, 1'b0, 1'b0, acc);
        send(64'h0FED_CBA9_8765_4321, 6'd7, 1'b1, 1'b0, 1'b0, acc);
        step();
        flush = 1'b1; in_valid = 1'b1; rs1 = 64'hAAAA_5555_AAAA_5555; sh = 6'd1;
        @(negedge CLK);
        check("flush_in_ready", b32.in_ready, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge CLK);
        check("flush_cleared32", b32.out_valid, 1'b0);
        check("flush_cleared64", b64.out_valid, 1'b0);
        repeat (3) step();
        op_lat("lat_after_flush", 64'h0000_0000_0000_00F0, 6'd4, 1'b1, 1'b0, 1'b0);

        // Reset while the result stage is occupied and stalled.
        step();
        out_ready = 1'b0;
        send(64'hFFFF_0000_FFFF_0000, 6'd8, 1'b0, 1'b0, 1'b0, acc);
        wait_out(acc, lat);
        check("pre_rst_lat", lat, 2);
        step();
        RST = 1'b1;
        step();
        check("rst_mid_out_valid32", b32.out_valid, 1'b0);
        check("rst_mid_result32", b32.Result, 64'd0);
        check("rst_mid_out_valid64", b64.out_valid, 1'b0);
        check("rst_mid_result64", b64.Result, 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("rst_mid_in_ready", b32.in_ready, 1'b1);
        step();
        out_ready = 1'b1;

        // Random traffic with random backpressure and occasional flush.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(9) < 7);
            rs1       = ($urandom_range(3) == 0) ? {1'b1, 31'($urandom), 1'b1, 31'($urandom)}
                                                 : {$urandom, $urandom};
            sh        = 6'($urandom);
            f3        = 1'($urandom);
            f7        = 1'($urandom);
            rot       = 1'($urandom);
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(39) == 0);
            step();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/shift_pipe.md
SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 SHALL provide parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 SHALL provide parameter SHW, default $clog2(XLEN), shift-amount width; not overridden independently of XLEN.
REQ-003 SHALL provide port CLK  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL provide port flush  input  1  discard all in-flight operations.
REQ-006 SHALL provide port in_valid  input  1  request present.
REQ-007 SHALL provide port in_ready  output  1  request accepted this cycle when high with in_valid.
REQ-008 SHALL provide port Rs1  input  XLEN  operand.
REQ-009 SHALL provide port Shamt  input  SHW  shift amount.
REQ-010 SHALL provide port funct3_2  input  1  direction: 0 left, 1 right.
REQ-011 SHALL provide port funct7_5  input  1  arithmetic select for right shift.
REQ-012 SHALL provide port Rot  input  1  rotate select; only active per REQ-030.
REQ-013 SHALL provide port out_valid  output  1  Result holds a completed operation.
REQ-014 SHALL provide port out_ready  input  1  consumer takes Result.
REQ-015 SHALL provide port Result  output  XLEN  shifted value.

Function
REQ-016 SHALL decode {funct7_5,funct3_2} with Rot=0: 00 SLL, 01 SRL, 11 SRA, 10 illegal -> Result all-zero (operation still occupies a slot and produces out_valid).
REQ-017 SHALL fill vacated bits with Rs1[XLEN-1] for SRA, zero otherwise; Shamt=0 returns Rs1 unchanged for every legal op.
REQ-018 SHALL implement left shifts by bit-reversal around a single right-shift network (one shared logarithmic network, SHW levels).
REQ-019 SHALL be a two-stage pipeline: stage 1 registers operand after input reversal and levels Shamt[SHW/2-1:0] (integer division); stage 2 applies remaining levels and output reversal into Result register.
REQ-020 SHALL accept a request when in_valid && in_ready; latency from acceptance edge to out_valid high SHALL be exactly 2 cycles with out_ready held high.
REQ-021 SHALL sustain one accepted operation per cycle while out_ready is high.
REQ-022 SHALL advance each stage when its successor is empty or advancing; in_ready = !s1_valid || s1_advance (combinational from out_ready, no combinational path from in_valid).
REQ-023 SHALL hold Result and out_valid stable while out_valid && !out_ready; no operation lost or duplicated under any backpressure pattern.
REQ-024 SHALL preserve acceptance order of results.
REQ-025 SHALL, on flush, clear both stage valid bits at the next edge; a request presented in the same cycle as flush SHALL NOT be accepted (in_ready forced low while flush high).
REQ-026 SHALL ignore Rs1/Shamt/function inputs when in_valid is low; data registers need not be cleared, valid bits govern.

Reset
REQ-027 SHALL, while RST high at a clock edge, clear all valid bits; out_valid=0, Result=0, in_ready=0 during RST, in_ready=1 first cycle after RST drops.
REQ-028 SHALL give RST priority over flush and over any handshake; reset mid-operation drops in-flight results with no out_valid pulse.

Configuration
REQ-029 SHALL use macro SHIFT_PIPE_ROTATE_EN.
REQ-030 SHALL, when SHIFT_PIPE_ROTATE_EN defined and Rot=1, perform ROL (funct3_2=0) or ROR (funct3_2=1), funct7_5 ignored, vacated bits filled with wrapped-out bits.
REQ-031 SHALL, when undefined, ignore Rot entirely (treated as 0) and synthesise no rotate logic; Rot port still present.

Verification
REQ-032 XLEN=32, SRA Rs1=0x8000_0000 Shamt=31 -> Result 0xFFFF_FFFF exactly 2 cycles after acceptance.
REQ-033 XLEN=64, SLL Rs1=1 Shamt=63 -> 0x8000_0000_0000_0000; SRL same Shamt on that value -> 1; illegal {1,0} -> 0 with out_valid.
REQ-034 Back-to-back 8 requests, out_ready low cycles 3-6 -> in_ready low once both stages full, 8 results in order, none duplicated.
REQ-035 Two ops in flight, flush pulse with in_valid high -> no out_valid for either, flush-cycle request not accepted, next request completes in 2 cycles.
REQ-036 RST asserted while stage 2 valid and out_ready low -> out_valid 0 next cycle, Result 0, in_ready 1 after RST release.
REQ-037 SHIFT_PIPE_ROTATE_EN defined, Rot=1 ROR Rs1=0x0000_0001 Shamt=4 -> 0x1000_0000; undefined, same stimulus -> SRL result 0x0000_0000.
